// File: rtl/npc_bp_if.sv
// Bundle of fetch-side and EX-side signals between the pipeline and the next-PC unit.
interface npc_bp_if #(
    parameter int unsigned WIDTH = 32
);
    // fetch side
    logic             stall;
    logic [31:0]      if_instr;
    logic [WIDTH-1:0] pc;
    logic             pred_taken;

    // EX resolution side
    logic             ex_valid;
    logic [WIDTH-1:0] ex_pc;
    logic [2:0]       ex_npcop;
    logic [25:0]      ex_imm;
    logic [4:0]       ex_rt;
    logic [WIDTH-1:0] ex_rd1;
    logic             ex_zero;
    logic             ex_pred_taken;

    // redirect / statistics
    logic             flush;
    logic [15:0]      mispred_cnt;

    // pipeline side: drives fetch/EX info, consumes pc and redirect
    modport master (
        output stall, if_instr, ex_valid, ex_pc, ex_npcop, ex_imm,
               ex_rt, ex_rd1, ex_zero, ex_pred_taken,
        input  pc, pred_taken, flush, mispred_cnt
    );

    // next-PC unit side
    modport slave (
        input  stall, if_instr, ex_valid, ex_pc, ex_npcop, ex_imm,
               ex_rt, ex_rd1, ex_zero, ex_pred_taken,
        output pc, pred_taken, flush, mispred_cnt
    );
endinterface

// File: rtl/npc_bp.sv
// Next-PC unit: PC register, 2-bit counter direction predictor at fetch,
// branch resolution in EX with one-cycle redirect/flush, mispredict counter.
module npc_bp #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     BHT_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000)
) (
    input logic      clk,
    input logic      rst,
    npc_bp_if.slave  bus
);
    localparam int unsigned IDX = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        OP_PLUS4  = 3'd0,
        OP_BEQ    = 3'd1,
        OP_BNE    = 3'd2,
        OP_JUMP   = 3'd3,
        OP_REG    = 3'd4,
        OP_BLEZ   = 3'd5,
        OP_BGTZ   = 3'd6,
        OP_REGIMM = 3'd7
    } npc_op_e;

    logic [WIDTH-1:0] pc_q;
    logic [1:0]       ctr_q [BHT_DEPTH];
    logic [15:0]      mispred_q;

    // fetch-side combinational signals
    logic             f_cond_c;
    logic             f_jump_c;
    logic [IDX-1:0]   f_idx_c;
    logic             f_pred_c;
    logic [WIDTH-1:0] f_pc4_c;
    logic [WIDTH-1:0] f_boff_c;
    logic [WIDTH-1:0] f_next_c;

    // EX-side combinational signals
    logic             ex_cond_c;
    logic             ex_reg_c;
    logic             ex_taken_c;
    logic             ex_neg_c;
    logic             ex_rd1_zero_c;
    logic [IDX-1:0]   ex_idx_c;
    logic [WIDTH-1:0] ex_seq_c;
    logic [WIDTH-1:0] ex_boff_c;
    logic [WIDTH-1:0] ex_target_c;
    logic             redirect_c;
    logic [WIDTH-1:0] pc_next_c;

    // upper immediate bits only matter to the jump path, which never redirects
    logic unused_imm_hi;
    assign unused_imm_hi = ^bus.ex_imm[25:16];

    // Fetch decode and prediction from the counter table.
    always_comb begin
        f_cond_c = 1'b0;
        f_jump_c = 1'b0;
        case (bus.if_instr[31:26])
            6'b000001,
            6'b000100,
            6'b000101,
            6'b000110,
            6'b000111: f_cond_c = 1'b1;
            6'b000010,
            6'b000011: f_jump_c = 1'b1;
            default: ;
        endcase
        f_idx_c  = pc_q[IDX+1:2];
        f_pred_c = (f_cond_c & ctr_q[f_idx_c][1]) | f_jump_c;
    end

    // Fetch-side next PC: jump region target, predicted branch target, or pc+4.
    always_comb begin
        f_pc4_c  = pc_q + WIDTH'(4);
        f_boff_c = {{(WIDTH-18){bus.if_instr[15]}}, bus.if_instr[15:0], 2'b00};
        if (f_jump_c) begin
            f_next_c = (f_pc4_c & ~WIDTH'(28'hFFF_FFFF))
                     | WIDTH'({bus.if_instr[25:0], 2'b00});
        end else if (f_cond_c & f_pred_c) begin
            f_next_c = f_pc4_c + f_boff_c;
        end else begin
            f_next_c = f_pc4_c;
        end
    end

    // EX resolution: actual direction and architectural target.
    always_comb begin
        ex_cond_c     = 1'b0;
        ex_reg_c      = 1'b0;
        ex_taken_c    = 1'b0;
        ex_neg_c      = bus.ex_rd1[WIDTH-1];
        ex_rd1_zero_c = (bus.ex_rd1 == '0);
        ex_idx_c      = bus.ex_pc[IDX+1:2];
        case (npc_op_e'(bus.ex_npcop))
            OP_BEQ: begin
                ex_cond_c  = 1'b1;
                ex_taken_c = bus.ex_zero;
            end
            OP_BNE: begin
                ex_cond_c  = 1'b1;
                ex_taken_c = ~bus.ex_zero;
            end
            OP_BLEZ: begin
                ex_cond_c  = 1'b1;
                ex_taken_c = ex_neg_c | ex_rd1_zero_c;
            end
            OP_BGTZ: begin
                ex_cond_c  = 1'b1;
                ex_taken_c = ~ex_neg_c & ~ex_rd1_zero_c;
            end
            OP_REGIMM: begin
                ex_cond_c = 1'b1;
                case (bus.ex_rt)
                    5'd0:    ex_taken_c = ex_neg_c;
                    5'd1:    ex_taken_c = ~ex_neg_c;
                    default: ex_taken_c = 1'b0;
                endcase
            end
            OP_REG: ex_reg_c = 1'b1;
            default: ;
        endcase
    end

    // Redirect decision and EX target selection.
    always_comb begin
        ex_seq_c  = bus.ex_pc + WIDTH'(4);
        ex_boff_c = {{(WIDTH-18){bus.ex_imm[15]}}, bus.ex_imm[15:0], 2'b00};
        if (ex_reg_c) begin
            ex_target_c = bus.ex_rd1;
        end else if (ex_cond_c & ex_taken_c) begin
            ex_target_c = ex_seq_c + ex_boff_c;
        end else begin
            ex_target_c = ex_seq_c;
        end
        redirect_c = bus.ex_valid
                   & ((ex_cond_c & (ex_taken_c != bus.ex_pred_taken)) | ex_reg_c);
    end

    // Next PC priority: redirect over stall over fetch prediction.
    always_comb begin
        if (redirect_c) begin
            pc_next_c = ex_target_c;
        end else if (bus.stall) begin
            pc_next_c = pc_q;
        end else begin
            pc_next_c = f_next_c;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next_c;
        end
    end

    // Counter table training on resolved conditional branches; ignores stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (bus.ex_valid & ex_cond_c) begin
            if (ex_taken_c) begin
                if (ctr_q[ex_idx_c] != 2'b11) begin
                    ctr_q[ex_idx_c] <= ctr_q[ex_idx_c] + 2'd1;
                end
            end else begin
                if (ctr_q[ex_idx_c] != 2'b00) begin
                    ctr_q[ex_idx_c] <= ctr_q[ex_idx_c] - 2'd1;
                end
            end
        end
    end

    // Saturating redirect counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_q <= 16'd0;
        end else if (redirect_c && (mispred_q != 16'hFFFF)) begin
            mispred_q <= mispred_q + 16'd1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = f_pred_c;
    assign bus.flush       = redirect_c;
    assign bus.mispred_cnt = mispred_q;

endmodule

// File: doc/npc_bp.md
# npc_bp

Parametrised next-PC unit for the pipelined CPU: owns the PC register, predicts branch direction at fetch using a direct-mapped table of 2-bit saturating counters, and resolves the real outcome in EX. It issues a one-cycle redirect/flush on mispredict and keeps a saturating mispredict counter for performance runs. It sits between IM (fetch) and the EX-stage branch comparator, replacing the single-cycle next-PC mux.

## Interface
- WIDTH, 32, PC/data width (≥ 28)
- BHT_DEPTH, 16, counter-table entries (power of 2, 2..256); IDX = log2(BHT_DEPTH)
- RESET_PC, 32'h0000_3000, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (hazard unit)
- if_instr  in  32  instruction currently fetched at pc
- pc  out  WIDTH  fetch PC (register)
- pred_taken  out  1  fetch-stage prediction for if_instr, carried down the pipe
- ex_valid  in  1  one-cycle pulse: the instruction in EX is resolved this cycle
- ex_pc  in  WIDTH  PC of the EX instruction
- ex_npcop  in  3  0 PLUS4, 1 BEQ, 2 BNE, 3 JUMP, 4 REG, 5 BLEZ, 6 BGTZ, 7 REGIMM
- ex_imm  in  26  instr[25:0] of EX instruction
- ex_rt  in  5  rt field (REGIMM sub-op)
- ex_rd1  in  WIDTH  rs value (jr/jalr target, compare operand)
- ex_zero  in  1  ALU zero (rs == rt)
- ex_pred_taken  in  1  pred_taken carried with the EX instruction
- flush  out  1  kill IF/ID contents this cycle
- mispred_cnt  out  16  saturating count of redirects

## Operation
- Fetch decode on if_instr[31:26]: cond branch = 000001, 000100..000111; jump = 000010/000011; else sequential.
- Fetch index = pc[IDX+1:2]; pred_taken = cond branch & ctr[idx][1], or jump. Zero otherwise.
- Fetch next: jump → {pc4[WIDTH-1:28], if_instr[25:0], 2'b00}; cond & predicted → pc4 + sext(if_instr[15:0])<<2; else pc4 (pc4 = pc+4, wrap modulo 2^WIDTH).
- EX actual taken: BEQ zero; BNE !zero; BLEZ rd1[31] | rd1==0; BGTZ !rd1[31] & rd1!=0; REGIMM rt=0 (bltz) rd1[31], rt=1 (bgez) !rd1[31], other rt not taken.
- EX target: taken cond → ex_pc+4+sext(ex_imm[15:0])<<2, not taken → ex_pc+4; REG → ex_rd1.
- Redirect (flush=1) when ex_valid and: conditional with actual ≠ ex_pred_taken, or REG (never predicted). JUMP/PLUS4 never redirect.
- Next PC priority: rst > redirect (EX target) > stall (hold) > fetch next.
- Counter update on ex_valid & conditional op, index ex_pc[IDX+1:2]: taken → +1 sat at 3, not taken → −1 sat at 0. Independent of stall.
- mispred_cnt +1 per redirect, saturates at 16'hFFFF.

## Timing
- Reset (async): pc=RESET_PC, all counters=2'b01, mispred_cnt=0. flush/pred_taken combinational; with ex_valid=0 after reset flush=0.
- pred_taken, flush: combinational, same cycle as inputs.
- Redirect latency: pc equals EX target on the edge following the ex_valid mispredict cycle.
- Same-cycle counter update and fetch lookup on same index: fetch sees the pre-update value (no bypass).
- Redirect during stall: redirect wins; pc loads target.
- Reset asserted mid-redirect: pc=RESET_PC, table reinitialised, no pending state survives.
- ex_valid must pulse exactly once per resolved instruction; block does not dedupe.

## Test plan
- Reset release, no branches, stall=0: pc 0x3000, 0x3004, 0x3008 each cycle; flush=0, pred_taken=0.
- if_instr = j 0x0C01 at pc 0x3000: pred_taken=1, next pc=0x0000_3004 upper | 0x3004 → 0x0003004 target {0x0,0x0C01<<2}=0x3004; no flush when resolved in EX.
- BEQ at ex_pc 0x3010, imm 4, zero=1, ex_pred_taken=0: flush=1, next pc=0x3024, ctr[4] 01→10, mispred_cnt=1; next fetch of 0x3010 gives pred_taken=1.
- jr with ex_rd1=0x4000, stall=1: flush=1, pc=0x4000 next cycle despite stall.
- Same branch resolved taken 4×: counter saturates at 3; then not taken once → 2, prediction still taken, redirect issued.
- Assert rst while ex_valid mispredict active: pc=RESET_PC immediately, mispred_cnt=0, counters 01.
